sequential_signed_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier with a run-time unsigned/signed (two's complement) mode select, a busy flag and a one-cycle ready pulse. It is the next generation of the team's sequential multiplier and keeps the same Start/ready handshake, so existing controllers and benches can drive it. It sits beside the datapath ALU as a multi-cycle arithmetic unit. One product is computed per request, one multiplier bit per clock.

---
 rtl/sequential_signed_multiplier_if.sv | 12 +
 rtl/sequential_signed_multiplier.sv | 82 ++++++++
 tb/tb_sequential_signed_multiplier.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sequential_signed_multiplier_if.sv
// sequential_signed_multiplier_if: request/response bundle for the sequential multiplier
interface sequential_signed_multiplier_if #(parameter int WORD_LENGTH = 16);
   logic                     Start;
   logic                     Signed_Mode;
   logic [WORD_LENGTH-1:0]   Multiplicand;
   logic [WORD_LENGTH-1:0]   Multiplier;
   logic                     busy;
   logic                     ready;
   logic [2*WORD_LENGTH-1:0] Product;
   modport master (output Start, Signed_Mode, Multiplicand, Multiplier, input busy, ready, Product);
   modport slave (input Start, Signed_Mode, Multiplicand, Multiplier, output busy, ready, Product);
endinterface

// File: rtl/sequential_signed_multiplier.sv
// sequential_signed_multiplier: shift-add multiplier, one multiplier bit per clock, unsigned or two's complement
module sequential_signed_multiplier #(
   parameter int WORD_LENGTH = 16
) (
   input logic clk,
   input logic reset,
   sequential_signed_multiplier_if.slave io
);
   localparam int W  = WORD_LENGTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
   logic signed_q, signed_d;
   logic [2*W:0] acc_q, acc_d;
   logic [2*W-1:0] product_q, product_d;
   logic ready_q, ready_d;
   logic [W:0] ext, addend, sum;
   logic [2*W:0] shifted;
   // Next state: latch request in IDLE, one add/subtract-and-shift per cycle in BUSY
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      signed_d  = signed_q;
      acc_d     = acc_q;
      product_d = product_q;
      ready_d   = 1'b0;
      ext       = signed_q ? {mcand_q[W-1], mcand_q} : {1'b0, mcand_q};
      addend    = mplier_q[0] ? ((signed_q && cnt_q == LAST) ? -ext : ext) : '0;
      sum       = acc_q[2*W:W] + addend;
      shifted   = {signed_q ? sum[W] : 1'b0, sum, acc_q[W-1:1]};
      if (state_q == IDLE) begin
         if (io.Start) begin
            state_d  = BUSY;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = io.Multiplicand;
            mplier_d = io.Multiplier;
            signed_d = io.Signed_Mode;
         end
      end else begin
         acc_d    = shifted;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            product_d = shifted[2*W-1:0];
            ready_d   = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
         end
      end
   end
   // State registers; reset aborts any operation and clears the result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         signed_q  <= 1'b0;
         acc_q     <= '0;
         product_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         signed_q  <= signed_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         ready_q   <= ready_d;
      end
   end
   assign io.busy    = state_q == BUSY;
   assign io.ready   = ready_q;
   assign io.Product = product_q;
endmodule

// File: tb/tb_sequential_signed_multiplier.sv
// tb_sequential_signed_multiplier: directed vectors with hand-computed products
module tb_sequential_signed_multiplier;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   sequential_signed_multiplier_if #(.WORD_LENGTH(16)) io ();
   sequential_signed_multiplier #(.WORD_LENGTH(16)) dut (.clk(clk), .reset(reset), .io(io));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
      io.Signed_Mode  = s;
      io.Multiplicand = a;
      io.Multiplier   = b;
      io.Start        = 1'b1;
      step();
      io.Start = 1'b0;
   endtask
   task automatic wait_ready(output int n);
      n = 0;
      while (!io.ready && n < 40) begin
         step();
         n++;
      end
   endtask
   task automatic run(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
      int n;
      launch(s, a, b);
      chk({tag, "_busy"}, 64'(io.busy), 64'd1);
      wait_ready(n);
      chk({tag, "_lat"}, 64'(n), 64'd16);
      chk({tag, "_prod"}, 64'(io.Product), 64'(exp));
      chk({tag, "_busy_done"}, 64'(io.busy), 64'd0);
      step();
      chk({tag, "_ready_pulse"}, 64'(io.ready), 64'd0);
   endtask
   initial begin
      int n;
      int pulses;
      int rc;
      logic busy15;
      io.Start = 1'b0;
      io.Signed_Mode = 1'b0;
      io.Multiplicand = '0;
      io.Multiplier = '0;
      step();
      step();
      reset = 1'b0;
      chk("rst_busy", 64'(io.busy), 64'd0);
      chk("rst_ready", 64'(io.ready), 64'd0);
      chk("rst_prod", 64'(io.Product), 64'd0);
      run("u8x12", 1'b0, 16'd8, 16'd12, 32'd96);
      run("s_m3x7", 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB);
      run("u_fffdx7", 1'b0, 16'hFFFD, 16'h0007, 32'h0006FFEB);
      run("s_minxmin", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
      run("s_minx1", 1'b1, 16'h8000, 16'h0001, 32'hFFFF8000);
      run("u_maxxmax", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      run("s_0x1234", 1'b1, 16'h0000, 16'h1234, 32'h0);
      run("u_0x1234", 1'b0, 16'h0000, 16'h1234, 32'h0);
      run("s_7xm3", 1'b1, 16'h0007, 16'hFFFD, 32'hFFFFFFEB);
      // Start while busy is ignored and operand changes do not disturb the result
      launch(1'b0, 16'd8, 16'd12);
      pulses = 0;
      rc = 0;
      busy15 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 4) begin
            io.Start = 1'b1;
            io.Multiplicand = 16'd30;
            io.Multiplier = 16'd4;
         end else begin
            io.Start = 1'b0;
            io.Multiplicand = 16'($urandom);
            io.Multiplier = 16'($urandom);
            io.Signed_Mode = 1'($urandom);
         end
         step();
         if (io.ready) begin
            pulses++;
            rc = c;
         end
         if (c == 15) busy15 = io.busy;
         if (c == 16) begin
            chk("ign_prod", 64'(io.Product), 64'd96);
            chk("ign_busy16", 64'(io.busy), 64'd0);
         end
      end
      chk("ign_pulses", 64'(pulses), 64'd1);
      chk("ign_ready_cycle", 64'(rc), 64'd16);
      chk("ign_busy15", 64'(busy15), 64'd1);
      // Reset mid-operation aborts without a ready pulse
      launch(1'b0, 16'd30, 16'd4);
      for (int c = 1; c <= 4; c++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rmid_busy", 64'(io.busy), 64'd0);
      chk("rmid_ready", 64'(io.ready), 64'd0);
      chk("rmid_prod", 64'(io.Product), 64'd0);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (io.ready) pulses++;
      end
      chk("rmid_no_ready", 64'(pulses), 64'd0);
      run("rmid_fresh", 1'b0, 16'd30, 16'd4, 32'd120);
      // Reset and Start on the same edge: reset wins
      io.Start = 1'b1;
      reset = 1'b1;
      step();
      io.Start = 1'b0;
      reset = 1'b0;
      chk("rst_start_busy", 64'(io.busy), 64'd0);
      // Back-to-back: new Start accepted in the ready cycle
      launch(1'b0, 16'd8, 16'd12);
      wait_ready(n);
      chk("b2b_lat1", 64'(n), 64'd16);
      chk("b2b_prod1", 64'(io.Product), 64'd96);
      launch(1'b0, 16'd30, 16'd4);
      chk("b2b_busy", 64'(io.busy), 64'd1);
      chk("b2b_hold", 64'(io.Product), 64'd96);
      for (int c = 1; c <= 15; c++) step();
      chk("b2b_hold15", 64'(io.Product), 64'd96);
      chk("b2b_ready15", 64'(io.ready), 64'd0);
      step();
      chk("b2b_ready2", 64'(io.ready), 64'd1);
      chk("b2b_prod2", 64'(io.Product), 64'd120);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
